linebuf_scheduler: RTL and testbench

LINEBUF_SCHEDULER -- requirements
Module: linebuf_scheduler

---
 rtl/linebuf_scheduler.sv | 134 +++++++++++++
 tb/tb_linebuf_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/linebuf_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : linebuf_scheduler
//  Description : Write/read scheduler for a three-bank video line buffer.
//                Counts pixels within a line and rotates the write bank on
//                every completed line. It reports which banks hold the two
//                previous lines, and flags when a FilterSize x FilterSize
//                window around the current pixel is complete.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clock      in   rising-edge clock
//    Reset      in   synchronous, active-low reset
//    VSync      in   frame sync (restarts the frame)
//    HSync      in   line sync (ends the current line)
//    VDE        in   active-video pixel strobe
//    WrEn       out  line-buffer write enable
//    WrBank     out  bank being written (0..2)
//    RdBankMid  out  bank holding the previous line
//    RdBankTop  out  bank holding the line before that
//    PixAddr    out  column address of the sampled pixel
//    WinValid   out  current pixel completes a full window
//    LineCount  out  completed lines in the frame (saturating)
//    State      out  0 IDLE, 1 FILL, 2 RUN
//    LineErr    out  sticky truncated-line flag
// ============================================================================
module linebuf_scheduler #(
    parameter int XADRSWidth = 11,
    parameter int YADRSWidth = 10,
    parameter int EndLineH   = 1280,
    parameter int FilterSize = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  VSync,
    input  logic                  HSync,
    input  logic                  VDE,
    output logic                  WrEn,
    output logic [1:0]            WrBank,
    output logic [1:0]            RdBankMid,
    output logic [1:0]            RdBankTop,
    output logic [XADRSWidth-1:0] PixAddr,
    output logic                  WinValid,
    output logic [YADRSWidth-1:0] LineCount,
    output logic [1:0]            State,
    output logic                  LineErr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [XADRSWidth-1:0] c_LAST_COL  = XADRSWidth'(EndLineH - 1);
    localparam logic [XADRSWidth-1:0] c_WIN_COL   = XADRSWidth'(FilterSize - 1);
    localparam logic [YADRSWidth-1:0] c_RUN_LINES = YADRSWidth'(FilterSize - 1);

    state_t                  r_state;
    logic [XADRSWidth-1:0]   r_col;

    logic                    w_last;
    logic [1:0]              w_bank_nxt;
    logic [YADRSWidth-1:0]   w_count_inc;

    // Bank rotation 0->1->2->0; read banks trail the write bank by one/two.
    function automatic logic [1:0] bank_next(input logic [1:0] b);
        return (b == 2'd2) ? 2'd0 : b + 2'd1;
    endfunction

    function automatic logic [1:0] bank_prev(input logic [1:0] b);
        return (b == 2'd0) ? 2'd2 : b - 2'd1;
    endfunction

    assign w_last      = (r_col == c_LAST_COL);
    assign w_bank_nxt  = bank_next(WrBank);
    assign w_count_inc = (&LineCount) ? LineCount : LineCount + YADRSWidth'(1);
    assign State       = r_state;

    always_ff @(posedge Clock) begin
        // VSync restarts the frame exactly like reset does.
        if (!Reset || VSync) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            WrEn      <= 1'b0;
            WrBank    <= 2'd0;
            RdBankMid <= 2'd2;
            RdBankTop <= 2'd1;
            PixAddr   <= '0;
            WinValid  <= 1'b0;
            LineCount <= '0;
            LineErr   <= 1'b0;
        end else begin
            WrEn     <= 1'b0;
            PixAddr  <= '0;
            WinValid <= 1'b0;
            if (HSync) begin
                // A non-zero column means pixels were streaming right up to
                // this HSync, so the line is short: drop it and flag it.
                r_col <= '0;
                if (r_col != '0) begin
                    LineErr <= 1'b1;
                end
            end else if (VDE) begin
                WrEn     <= 1'b1;
                PixAddr  <= r_col;
                // Uses the pre-edge state, so the line that completes the
                // FILL phase never reports a valid window itself.
                WinValid <= (r_state == ST_RUN) && (r_col >= c_WIN_COL);
                if (w_last) begin
                    r_col     <= '0;
                    WrBank    <= w_bank_nxt;
                    RdBankMid <= bank_prev(w_bank_nxt);
                    RdBankTop <= bank_next(w_bank_nxt);
                    LineCount <= w_count_inc;
                    if (r_state != ST_RUN && w_count_inc >= c_RUN_LINES) begin
                        r_state <= ST_RUN;
                    end else if (r_state == ST_IDLE) begin
                        r_state <= ST_FILL;
                    end
                end else begin
                    r_col <= r_col + XADRSWidth'(1);
                    if (r_state == ST_IDLE) begin
                        r_state <= ST_FILL;
                    end
                end
            end else begin
                r_col <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_linebuf_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_linebuf_scheduler
//  Description : Self-checking bench for linebuf_scheduler with a frame-level
//                reference model (column position, lines completed, started
//                flag, error flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_linebuf_scheduler;

    localparam int XW  = 11;
    localparam int YW  = 4;
    localparam int EH  = 8;
    localparam int FS  = 3;
    localparam int SAT = (1 << YW) - 1;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          VSync = 1'b0;
    logic          HSync = 1'b0;
    logic          VDE   = 1'b0;
    logic          WrEn;
    logic [1:0]    WrBank;
    logic [1:0]    RdBankMid;
    logic [1:0]    RdBankTop;
    logic [XW-1:0] PixAddr;
    logic          WinValid;
    logic [YW-1:0] LineCount;
    logic [1:0]    State;
    logic          LineErr;

    linebuf_scheduler #(
        .XADRSWidth (XW),
        .YADRSWidth (YW),
        .EndLineH   (EH),
        .FilterSize (FS)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .VSync     (VSync),
        .HSync     (HSync),
        .VDE       (VDE),
        .WrEn      (WrEn),
        .WrBank    (WrBank),
        .RdBankMid (RdBankMid),
        .RdBankTop (RdBankTop),
        .PixAddr   (PixAddr),
        .WinValid  (WinValid),
        .LineCount (LineCount),
        .State     (State),
        .LineErr   (LineErr)
    );

    always #5 Clock = ~Clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: frame-level view of the stream.
    int m_col     = 0;
    int m_lines   = 0;
    bit m_started = 0;
    bit m_err     = 0;
    logic [25:0] exp_v;
    wire  [25:0] got_v = {WrEn, WrBank, RdBankMid, RdBankTop, PixAddr,
                          WinValid, LineCount, State, LineErr};

    function automatic int mode();
        if (!m_started)        return 0;
        if (m_lines >= FS - 1) return 2;
        return 1;
    endfunction

    // Drive one clock of inputs, advance the model, and leave the bench
    // 1 time unit after the active edge with exp_v describing the outputs.
    task automatic cyc(input bit rst_n, input bit vs, input bit hs, input bit vde);
        bit          e_wr;
        int          e_addr;
        bit          e_win;
        int          bank;
        int          cnt;
        e_wr = 0; e_addr = 0; e_win = 0;
        if (!rst_n || vs) begin
            m_col = 0; m_lines = 0; m_started = 0; m_err = 0;
        end else if (hs) begin
            if (m_col != 0) m_err = 1;
            m_col = 0;
        end else if (vde) begin
            e_wr   = 1;
            e_addr = m_col;
            e_win  = (mode() == 2) && (m_col >= FS - 1);
            m_started = 1;
            m_col++;
            if (m_col == EH) begin
                m_col = 0;
                m_lines++;
            end
        end else begin
            m_col = 0;
        end
        bank  = m_lines % 3;
        cnt   = (m_lines > SAT) ? SAT : m_lines;
        exp_v = {e_wr, 2'(bank), 2'((bank + 2) % 3), 2'((bank + 1) % 3),
                 XW'(e_addr), e_win, YW'(cnt), 2'(mode()), m_err};
        Reset = rst_n; VSync = vs; HSync = hs; VDE = vde;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", got_v, exp_v);
        end
        n_cmp++;
        if ({State, WrBank, RdBankMid, RdBankTop, WrEn, LineCount} !== {2'd0, 2'd0, 2'd2, 2'd1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got st=%0d wb=%0d mid=%0d top=%0d wr=%0d lc=%0d expected 0 0 2 1 0 0",
                     State, WrBank, RdBankMid, RdBankTop, WrEn, LineCount);
        end
        n_cmp++;
    endtask

    task automatic test_fill_run();
        for (int ln = 0; ln < 3; ln++) begin
            cyc(1, 0, 1, 0);
            for (int c = 0; c < EH; c++) begin
                cyc(1, 0, 0, 1);
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL fill_run_l%0d_c%0d: got %h expected %h", ln, c, got_v, exp_v);
                end
                n_cmp++;
                if (ln == 0 && c == 0 && State !== 2'd1) begin
                    n_fail++;
                    $display("FAIL fill_state: got %0d expected 1", State);
                end
                if (ln == 0 && c == 0) n_cmp++;
                if (ln == 2 && c < EH - 1 && (WinValid !== (c >= 2) || WrBank !== 2'd2 ||
                                               RdBankMid !== 2'd1 || RdBankTop !== 2'd0)) begin
                    n_fail++;
                    $display("FAIL run_window_c%0d: got win=%0d wb=%0d mid=%0d top=%0d expected win=%0d wb=2 mid=1 top=0",
                             c, WinValid, WrBank, RdBankMid, RdBankTop, (c >= 2));
                end
                if (ln == 2 && c < EH - 1) n_cmp++;
            end
            if (LineCount !== YW'(ln + 1) || WrBank !== 2'((ln + 1) % 3)) begin
                n_fail++;
                $display("FAIL line_end_%0d: got lc=%0d wb=%0d expected lc=%0d wb=%0d",
                         ln, LineCount, WrBank, ln + 1, (ln + 1) % 3);
            end
            n_cmp++;
            if (ln == 1 && State !== 2'd2) begin
                n_fail++;
                $display("FAIL run_entry: got %0d expected 2", State);
            end
            if (ln == 1) n_cmp++;
        end
    endtask

    task automatic test_truncate();
        cyc(1, 0, 1, 0);
        for (int c = 0; c < 5; c++) cyc(1, 0, 0, 1);
        cyc(1, 0, 1, 0);
        if (LineErr !== 1'b1 || WrBank !== 2'd0 || LineCount !== 4'd3) begin
            n_fail++;
            $display("FAIL truncate: got err=%0d wb=%0d lc=%0d expected 1 0 3", LineErr, WrBank, LineCount);
        end
        n_cmp++;
        for (int c = 0; c < EH; c++) begin
            cyc(1, 0, 0, 1);
            if (c == 0 && WrBank !== 2'd0) begin
                n_fail++;
                $display("FAIL truncate_same_bank: got %0d expected 0", WrBank);
            end
            if (c == 0) n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL truncate_refill_c%0d: got %h expected %h", c, got_v, exp_v);
            end
            n_cmp++;
        end
    endtask

    task automatic test_hsync_vde();
        cyc(1, 0, 1, 0);
        for (int c = 0; c < 3; c++) cyc(1, 0, 0, 1);
        cyc(1, 0, 1, 1);
        if (WrEn !== 1'b0 || PixAddr !== '0 || LineErr !== 1'b1) begin
            n_fail++;
            $display("FAIL hsync_vde: got wr=%0d addr=%0d err=%0d expected 0 0 1", WrEn, PixAddr, LineErr);
        end
        n_cmp++;
    endtask

    task automatic test_vsync();
        for (int c = 0; c < 4; c++) cyc(1, 0, 0, 1);
        cyc(1, 1, 0, 1);
        if (State !== 2'd0 || WrBank !== 2'd0 || LineCount !== '0 || LineErr !== 1'b0 || WinValid !== 1'b0) begin
            n_fail++;
            $display("FAIL vsync: got st=%0d wb=%0d lc=%0d err=%0d win=%0d expected all 0",
                     State, WrBank, LineCount, LineErr, WinValid);
        end
        n_cmp++;
    endtask

    task automatic test_reset_priority();
        cyc(1, 0, 0, 1);
        cyc(0, 1, 0, 1);
        if (got_v !== {1'b0, 2'd0, 2'd2, 2'd1, 11'd0, 1'b0, 4'd0, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_priority: got %h expected %h", got_v,
                     {1'b0, 2'd0, 2'd2, 2'd1, 11'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        end
        n_cmp++;
    endtask

    task automatic test_saturation();
        cyc(1, 1, 0, 0);
        for (int ln = 0; ln < SAT + 3; ln++) begin
            for (int c = 0; c < EH; c++) cyc(1, 0, 0, 1);
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL saturation_l%0d: got %h expected %h", ln, got_v, exp_v);
            end
            n_cmp++;
        end
        if (LineCount !== YW'(SAT)) begin
            n_fail++;
            $display("FAIL saturation_final: got %0d expected %0d", LineCount, SAT);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_vs, r_hs, r_vde;
            r_rst = ($urandom_range(0, 299) != 0);
            r_vs  = ($urandom_range(0, 249) == 0);
            r_hs  = ($urandom_range(0, 29) == 0);
            r_vde = ($urandom_range(0, 9) != 0);
            cyc(r_rst, r_vs, r_hs, r_vde);
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random_%0d: got %h expected %h", i, got_v, exp_v);
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_run();
        test_truncate();
        test_hsync_vde();
        test_vsync();
        test_reset_priority();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
